// File: rtl/block_addr_gen_if.sv
// Handshake and address bus between the block-scan address generator and the
// compression core / image memory side.
interface block_addr_gen_if #(
    parameter int IMG_W_LOG2 = 7,
    parameter int IMG_H_LOG2 = 7,
    parameter int BLK_LOG2   = 2
);
    logic                                start;
    logic                                scan_mode;
    logic                                stall;
    logic                                finish_ack;
    logic [IMG_W_LOG2+IMG_H_LOG2-1:0]    imem_address;
    logic                                wr;
    logic [2*BLK_LOG2-1:0]               addr_w;
    logic [IMG_H_LOG2-BLK_LOG2-1:0]      blk_row;
    logic [IMG_W_LOG2-BLK_LOG2-1:0]      blk_col;
    logic                                finish;
    logic                                frame_done;

    modport master (
        output start, scan_mode, stall, finish_ack,
        input  imem_address, wr, addr_w, blk_row, blk_col, finish, frame_done
    );

    modport slave (
        input  start, scan_mode, stall, finish_ack,
        output imem_address, wr, addr_w, blk_row, blk_col, finish, frame_done
    );
endinterface

// File: rtl/block_addr_gen.sv
// Walks a row-major frame one square block at a time, emitting a pixel read
// address and block-buffer write index per cycle; handshakes after each block.
module block_addr_gen #(
    parameter int IMG_W_LOG2 = 7,
    parameter int IMG_H_LOG2 = 7,
    parameter int BLK_LOG2   = 2
) (
    input  logic               clk,
    input  logic               reset,
    block_addr_gen_if.slave    bus
);
    localparam int B  = BLK_LOG2;
    localparam int CW = 2 * B;
    localparam int RW = IMG_H_LOG2 - B;
    localparam int KW = IMG_W_LOG2 - B;
    localparam int BW = RW + KW;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [BW-1:0] BLK_ONE = BW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACK, FRAME_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   col_q, col_d;
    logic            mode_q, mode_d;
    logic            finish_q, finish_d;
    logic            done_q, done_d;
    logic            restart;
    logic [B-1:0]    py, px;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            mode_q   <= 1'b0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            mode_q   <= mode_d;
            finish_q <= finish_d;
            done_q   <= done_d;
        end
    end

    assign restart = bus.start && (state_q == IDLE || state_q == FRAME_DONE);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        mode_d   = mode_q;
        finish_d = finish_q;
        done_d   = done_q;
        unique case (state_q)
            SCAN: begin
                if (!bus.stall) begin
                    count_d = count_q + CNT_ONE;
                    if (&count_q) begin
                        finish_d       = 1'b1;
                        // row:col as one counter, so a column wrap carries into the row
                        {row_d, col_d} = {row_q, col_q} + BLK_ONE;
                        if (&{row_q, col_q}) begin
                            state_d = FRAME_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_ACK;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.finish_ack) begin
                    state_d  = SCAN;
                    finish_d = 1'b0;
                    count_d  = '0;
                end
            end
            FRAME_DONE: begin
                if (bus.finish_ack) finish_d = 1'b0;
            end
            default: ;
        endcase
        if (restart) begin
            state_d  = SCAN;
            count_d  = '0;
            row_d    = '0;
            col_d    = '0;
            finish_d = 1'b0;
            done_d   = 1'b0;
            mode_d   = bus.scan_mode;
        end
    end

    // Column mode swaps which half of the count walks along x.
    assign {py, px} = mode_q ? {count_q[B-1:0], count_q[CW-1:B]} : count_q;

    assign bus.imem_address = {row_q, py, col_q, px};
    assign bus.wr           = (state_q == SCAN) && !bus.stall;
    assign bus.addr_w       = count_q;
    assign bus.blk_row      = row_q;
    assign bus.blk_col      = col_q;
    assign bus.finish       = finish_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_block_addr_gen.sv
// Self-checking bench for block_addr_gen: table vectors, hand sequences and a
// random walk against an arithmetic frame-scan model, on two parameter sets.
module tb_block_addr_gen;
    localparam int AW = 7, AH = 7, AB = 2;
    localparam int BW = 5, BH = 4, BB = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    block_addr_gen_if #(.IMG_W_LOG2(AW), .IMG_H_LOG2(AH), .BLK_LOG2(AB)) ifa();
    block_addr_gen_if #(.IMG_W_LOG2(BW), .IMG_H_LOG2(BH), .BLK_LOG2(BB)) ifb();

    block_addr_gen #(.IMG_W_LOG2(AW), .IMG_H_LOG2(AH), .BLK_LOG2(AB)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    block_addr_gen #(.IMG_W_LOG2(BW), .IMG_H_LOG2(BH), .BLK_LOG2(BB)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    int errors = 0, checks = 0;
    int sel = 0, mW = AW, mH = AH, mB = AB;
    // model: phase 0 idle, 1 scanning, 2 waiting for ack, 3 frame done
    int m_ph, m_blk, m_pix, m_mode, m_fin, m_done;
    int o_wr, o_addr, o_aw, o_row, o_col, o_fin, o_done;
    int last_wr, prev_fin, dut_fin_rises;
    int first_addr[64], first_row[64], first_col[64];

    typedef struct {
        bit st, md, sl, ak;
        int wr, addr, aw, fin;
    } vec_t;
    vec_t tv[18];
    int ras[16] = '{0, 1, 2, 3, 128, 129, 130, 131, 256, 257, 258, 259, 384, 385, 386, 387};
    int col[16] = '{0, 128, 256, 384, 1, 129, 257, 385, 2, 130, 258, 386, 3, 131, 259, 387};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_sel(input int s);
        sel = s;
        if (s == 0) begin mW = AW; mH = AH; mB = AB; end
        else begin mW = BW; mH = BH; mB = BB; end
    endtask

    task automatic drive(input bit st, input bit md, input bit sl, input bit ak);
        ifa.start = (sel == 0) && st; ifa.scan_mode = md; ifa.stall = (sel == 0) && sl;
        ifa.finish_ack = (sel == 0) && ak;
        ifb.start = (sel == 1) && st; ifb.scan_mode = md; ifb.stall = (sel == 1) && sl;
        ifb.finish_ack = (sel == 1) && ak;
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_wr = int'(ifa.wr); o_addr = int'(ifa.imem_address); o_aw = int'(ifa.addr_w);
            o_row = int'(ifa.blk_row); o_col = int'(ifa.blk_col);
            o_fin = int'(ifa.finish); o_done = int'(ifa.frame_done);
        end else begin
            o_wr = int'(ifb.wr); o_addr = int'(ifb.imem_address); o_aw = int'(ifb.addr_w);
            o_row = int'(ifb.blk_row); o_col = int'(ifb.blk_col);
            o_fin = int'(ifb.finish); o_done = int'(ifb.frame_done);
        end
    endtask

    function automatic int m_addr();
        int bs  = 1 << mB;
        int nbc = 1 << (mW - mB);
        int hi  = m_pix / bs;
        int lo  = m_pix % bs;
        int py  = (m_mode != 0) ? lo : hi;
        int px  = (m_mode != 0) ? hi : lo;
        return ((m_blk / nbc) * bs + py) * (1 << mW) + (m_blk % nbc) * bs + px;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_blk = 0; m_pix = 0; m_mode = 0; m_fin = 0; m_done = 0;
    endtask

    task automatic m_start(input bit md);
        m_ph = 1; m_blk = 0; m_pix = 0; m_fin = 0; m_done = 0; m_mode = int'(md);
    endtask

    task automatic model_check(input bit sl);
        int nbc = 1 << (mW - mB);
        chk("wr", o_wr, (m_ph == 1 && !sl) ? 1 : 0);
        chk("imem_address", o_addr, m_addr());
        chk("addr_w", o_aw, m_pix);
        chk("blk_row", o_row, m_blk / nbc);
        chk("blk_col", o_col, m_blk % nbc);
        chk("finish", o_fin, m_fin);
        chk("frame_done", o_done, m_done);
    endtask

    task automatic model_update(input bit st, input bit md, input bit sl, input bit ak);
        int npix = 1 << (2 * mB);
        int nblk = 1 << (mW + mH - 2 * mB);
        case (m_ph)
            0: if (st) m_start(md);
            1: if (!sl) begin
                if (m_pix == npix - 1) begin
                    m_pix = 0; m_fin = 1;
                    if (m_blk == nblk - 1) begin m_blk = 0; m_ph = 3; m_done = 1; end
                    else begin m_blk++; m_ph = 2; end
                end else m_pix++;
            end
            2: if (ak) begin m_ph = 1; m_fin = 0; m_pix = 0; end
            default: if (st) m_start(md); else if (ak) m_fin = 0;
        endcase
    endtask

    // One clock: apply inputs, check outputs against the model, take the edge.
    task automatic cyc(input bit st, input bit md, input bit sl, input bit ak);
        drive(st, md, sl, ak);
        #1;
        sample();
        model_check(sl);
        if (o_wr != 0) last_wr = o_addr;
        if (o_fin != 0 && prev_fin == 0) dut_fin_rises++;
        prev_fin = o_fin;
        if (m_ph == 1 && !sl && m_pix == 0 && m_blk < 64) begin
            first_addr[m_blk] = o_addr; first_row[m_blk] = o_row; first_col[m_blk] = o_col;
        end
        model_update(st, md, sl, ak);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        m_reset();
        #1;
        sample();
        model_check(1'b0);
        chk("reset_wr", o_wr, 0);
        chk("reset_addr", o_addr, 0);
        prev_fin = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_frame(input bit rnd_mode);
        int n = 0;
        while (m_ph != 3 && n < 40000) begin
            cyc(1'b0, rnd_mode && (($urandom % 2) == 1), 1'b0, m_ph == 2);
            n++;
        end
        if (n >= 40000) chk("frame_timeout", n, 0);
    endtask

    task automatic measure(input int stall_at, input int stall_len, output int n);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (n < 200) begin
            n++;
            if (n > stall_at && n <= stall_at + stall_len) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b0);
                chk("stall_wr", o_wr, 0);
                chk("stall_addr_w", o_aw, 5);
                chk("stall_addr", o_addr, 129);
            end else begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                if (stall_len > 0 && n == stall_at + stall_len + 1) chk("resume_addr_w", o_aw, 5);
            end
            if (o_fin != 0) break;
        end
    endtask

    task automatic fill_table(input bit mode);
        tv[0] = '{1'b1, mode, 1'b0, 1'b0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++)
            tv[i+1] = '{1'b0, ($urandom % 2) == 1, 1'b0, 1'b0, 1, mode ? col[i] : ras[i], i, 0};
        tv[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1};
    endtask

    task automatic run_table();
        for (int i = 0; i < 18; i++) begin
            cyc(tv[i].st, tv[i].md, tv[i].sl, tv[i].ak);
            chk("tbl_wr", o_wr, tv[i].wr);
            chk("tbl_addr", o_addr, tv[i].addr);
            chk("tbl_addr_w", o_aw, tv[i].aw);
            chk("tbl_finish", o_fin, tv[i].fin);
        end
    endtask

    task automatic rand_run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom % 700 == 0) do_reset();
            else cyc(($urandom % 30) == 0, ($urandom % 2) == 1, ($urandom % 4) == 0,
                     ($urandom % 3) == 0);
        end
    endtask

    initial begin
        int n;
        set_sel(0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        last_wr = -1; prev_fin = 0; dut_fin_rises = 0;
        @(posedge clk);
        #1;

        // block 0, raster then column (scan_mode toggled freely mid-block)
        do_reset();
        fill_table(1'b0);
        run_table();
        do_reset();
        fill_table(1'b1);
        run_table();

        // finish latency unstalled vs. three stall cycles at count 5
        measure(5, 0, n);
        chk("finish_latency", n, 17);
        measure(5, 3, n);
        chk("finish_latency_stalled", n, 20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ack_next_write", o_wr, 1);
        chk("ack_next_addr", o_addr, 4);

        // full default frame with immediate acks, then end-of-frame behaviour
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1);
        chk("blk1_addr", first_addr[1], 4);
        chk("blk31_addr", first_addr[31], 124);
        chk("blk32_addr", first_addr[32], 512);
        chk("blk32_row", first_row[32], 1);
        chk("blk32_col", first_col[32], 0);
        chk("last_write", last_wr, 16383);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_hold", o_done, 1);
        chk("done_finish", o_fin, 1);
        chk("done_wr", o_wr, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ack_clears_finish", o_fin, 0);
        chk("ack_keeps_done", o_done, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_wr", o_wr, 1);
        chk("restart_addr", o_addr, 0);
        chk("restart_done", o_done, 0);

        // 32x16 image, 8x8 blocks
        set_sel(1);
        do_reset();
        dut_fin_rises = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("small_blocks", dut_fin_rises, 8);
        chk("small_blk1_addr", first_addr[1], 8);
        chk("small_last_write", last_wr, 511);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("noack_restart_finish", o_fin, 0);
        chk("noack_restart_done", o_done, 0);
        chk("noack_restart_wr", o_wr, 1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_after_reset_wr", o_wr, 0);

        rand_run(4000);
        set_sel(0);
        do_reset();
        rand_run(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
